// File: rtl/redun_mont_seq.sv
// Job sequencer for the redundant-form Montgomery squaring core: holds the core in reset,
// launches it, counts T completions, returns the T-th result, with abort and a watchdog.
module redun_mont_seq #(
    parameter int SQ_W     = 1088,
    parameter int ITER_W   = 64,
    parameter int WDOG_CYC = 64,
    parameter int RST_CYC  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start_val,
    output logic              o_start_rdy,
    input  logic [SQ_W-1:0]   i_start_sq,
    input  logic [ITER_W-1:0] i_start_t,
    input  logic              i_abort,
    output logic              o_core_rst,
    output logic [SQ_W-1:0]   o_core_sq,
    output logic              o_core_val,
    input  logic [SQ_W-1:0]   i_core_mul,
    input  logic              i_core_val,
    output logic              o_res_val,
    input  logic              i_res_rdy,
    output logic [SQ_W-1:0]   o_res,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_err,
    output logic              o_busy
);
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WDOG_CYC - 1);
    localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
    localparam logic [RC_W-1:0]   RC_LOAD  = RC_W'(RST_CYC - 1);
    localparam logic [RC_W-1:0]   RC_ONE   = RC_W'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_RST  = 6'b000010,
        S_LOAD = 6'b000100,
        S_RUN  = 6'b001000,
        S_DONE = 6'b010000,
        S_ERR  = 6'b100000
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_core_rst;
    logic              r_core_val;
    logic              r_res_val;
    logic              r_err;
    logic [SQ_W-1:0]   r_core_sq;
    logic [SQ_W-1:0]   r_res;
    logic [ITER_W-1:0] r_t;
    logic [ITER_W-1:0] r_iter;
    logic [WD_W-1:0]   r_wdog;
    logic [RC_W-1:0]   r_rst_cnt;

    logic w_accept;
    logic w_t_zero;
    logic w_last_iter;
    logic w_wdog_hit;
    logic w_load_job;
    logic w_load_t0;

    // Both handshakes transfer on a rising edge where valid and ready are both high;
    // ready depends on state only, and valid/data are ignored while ready is low.
    assign o_start_rdy = (r_state == S_IDLE) || (r_state == S_ERR);
    assign o_busy      = (r_state != S_IDLE);
    assign w_accept    = o_start_rdy && i_start_val;
    assign w_t_zero    = (i_start_t == '0);
    assign w_last_iter = ((r_iter + ITER_ONE) == r_t);
    assign w_wdog_hit  = !i_core_val && (r_wdog == WD_LAST);
    assign w_load_job  = w_accept && (w_next == S_RST);
    assign w_load_t0   = w_accept && (w_next == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_t_zero ? S_DONE : S_RST;
            end
            S_RST: begin
                if (i_abort)                 w_next = S_IDLE;
                else if (r_rst_cnt == '0)    w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = i_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (i_abort)                         w_next = S_IDLE;
                else if (i_core_val && w_last_iter)  w_next = S_DONE;
                else if (w_wdog_hit)                 w_next = S_ERR;
            end
            S_DONE: begin
                if (i_abort || i_res_rdy) w_next = S_IDLE;
            end
            S_ERR: begin
                if (i_abort)       w_next = S_IDLE;
                else if (w_accept) w_next = w_t_zero ? S_DONE : S_RST;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Core control outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_core_rst <= 1'b1;
            r_core_val <= 1'b0;
            r_res_val  <= 1'b0;
            r_err      <= 1'b0;
            r_core_sq  <= '0;
            r_res      <= '0;
            r_t        <= '0;
            r_iter     <= '0;
            r_wdog     <= '0;
            r_rst_cnt  <= '0;
        end else begin
            r_core_rst <= (w_next != S_LOAD) && (w_next != S_RUN);
            r_core_val <= (r_state == S_LOAD) && (w_next == S_RUN);
            r_res_val  <= (w_next == S_DONE);
            if (w_load_job) begin
                r_core_sq <= i_start_sq;
                r_t       <= i_start_t;
                r_iter    <= '0;
                r_err     <= 1'b0;
                r_rst_cnt <= RC_LOAD;
            end
            if (w_load_t0) begin
                r_res <= i_start_sq;
                r_err <= 1'b0;
            end
            if ((r_state == S_RST) && (r_rst_cnt != '0)) begin
                r_rst_cnt <= r_rst_cnt - RC_ONE;
            end
            if (r_state == S_LOAD) begin
                r_wdog <= '0;
            end
            // An abort wins over a coincident completion or watchdog expiry.
            if ((r_state == S_RUN) && !i_abort) begin
                if (i_core_val) begin
                    r_iter <= r_iter + ITER_ONE;
                    r_wdog <= '0;
                    if (w_last_iter) r_res <= i_core_mul;
                end else begin
                    r_wdog <= r_wdog + WD_ONE;
                    if (w_wdog_hit) r_err <= 1'b1;
                end
            end
        end
    end

    assign o_core_rst = r_core_rst;
    assign o_core_val = r_core_val;
    assign o_core_sq  = r_core_sq;
    assign o_res_val  = r_res_val;
    assign o_res      = r_res;
    assign o_iter     = r_iter;
    assign o_err      = r_err;

endmodule
